// File: rtl/regfile_param.sv
// Parametrised register file: 2 combinational read ports, 1 write port, optional zero reg,
// write-to-read bypass and a sequential bulk-clear engine. REGFILE_SCOREBOARD_EN adds a pending-write scoreboard.
module regfile_param #(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            reg_write,
    input  logic [AW-1:0]   w_reg,
    input  logic [XLEN-1:0] w_data,
    input  logic [AW-1:0]   r_reg1,
    input  logic [AW-1:0]   r_reg2,
    output logic [XLEN-1:0] r_data1,
    output logic [XLEN-1:0] r_data2,
    input  logic            clear_req,
    output logic            busy,
    output logic            clear_done
`ifdef REGFILE_SCOREBOARD_EN
    ,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            pend1,
    output logic            pend2
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_e;

    state_e          state_q;
    logic [AW-1:0]   ptr_q;
    logic            busy_q;
    logic            done_q;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    logic wr_en, byp1, byp2;

    // Writes are dropped while clearing and, with ZERO_REG, when aimed at register 0.
    assign wr_en = reg_write && !busy_q && !((ZERO_REG != 0) && (w_reg == '0));
    assign byp1  = (BYPASS != 0) && wr_en && (w_reg == r_reg1);
    assign byp2  = (BYPASS != 0) && wr_en && (w_reg == r_reg2);

    always_comb begin
        r_data1 = regs_q[r_reg1];
        r_data2 = regs_q[r_reg2];
        if (byp1) r_data1 = w_data;
        if (byp2) r_data2 = w_data;
        if ((ZERO_REG != 0) && (r_reg1 == '0)) r_data1 = '0;
        if ((ZERO_REG != 0) && (r_reg2 == '0)) r_data2 = '0;
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[w_reg] = w_data;
        if (state_q == S_CLEAR) regs_d[ptr_q] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) regs_q <= '{default: '0};
        else       regs_q <= regs_d;
    end

    // Clear engine: one entry per cycle, terminal on the last index rather than pointer wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (clear_req) begin
                    state_q <= S_CLEAR;
                    ptr_q   <= '0;
                    busy_q  <= 1'b1;
                end
                S_CLEAR: if (ptr_q == AW'(NREGS - 1)) begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    ptr_q <= ptr_q + 1'b1;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign clear_done = done_q;

`ifdef REGFILE_SCOREBOARD_EN
    logic [NREGS-1:0] pend_q, pend_d;

    always_comb begin
        pend_d = pend_q;
        if (wr_en) pend_d[w_reg] = 1'b0;
        if (issue_valid && !busy_q) pend_d[issue_rd] = 1'b1;
        if ((state_q == S_CLEAR) && (ptr_q == '0)) pend_d = '0;
        if (ZERO_REG != 0) pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    assign pend1 = pend_q[r_reg1] && !byp1;
    assign pend2 = pend_q[r_reg2] && !byp2;
`endif

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed vector table, random traffic against an array model,
// bulk-clear and reset-mid-clear sequences, and scoreboard checks when REGFILE_SCOREBOARD_EN is set.
module tb_regfile_param;
    localparam int XLEN = 64;
    localparam int NREGS = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            reg_write;
    logic [AW-1:0]   w_reg;
    logic [XLEN-1:0] w_data;
    logic [AW-1:0]   r_reg1, r_reg2;
    logic [XLEN-1:0] r_data1, r_data2;
    logic            clear_req, busy, clear_done;
`ifdef REGFILE_SCOREBOARD_EN
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            pend1, pend2;
`endif

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] model [NREGS];

    regfile_param #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .reg_write(reg_write), .w_reg(w_reg), .w_data(w_data),
        .r_reg1(r_reg1), .r_reg2(r_reg2), .r_data1(r_data1), .r_data2(r_data2),
        .clear_req(clear_req), .busy(busy), .clear_done(clear_done)
`ifdef REGFILE_SCOREBOARD_EN
        , .issue_valid(issue_valid), .issue_rd(issue_rd), .pend1(pend1), .pend2(pend2)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected read value straight from the register-file rules.
    function automatic logic [XLEN-1:0] exp_rd(input int r, input bit we, input int w, input logic [XLEN-1:0] wd);
        if (r == 0) return '0;
        if (we && w == r) return wd;
        return model[r];
    endfunction

    task automatic write_cycle(input int w, input logic [XLEN-1:0] d);
        @(negedge clk);
        reg_write = 1'b1; w_reg = AW'(w); w_data = d;
        @(negedge clk);
        reg_write = 1'b0;
        if (w != 0) model[w] = d;
    endtask

    task automatic read_all(input string name);
        for (int i = 0; i < NREGS; i++) begin
            r_reg1 = AW'(i); r_reg2 = AW'(NREGS - 1 - i);
            #1;
            check(name, r_data1, model[i]);
            check(name, r_data2, model[NREGS - 1 - i]);
        end
    endtask

    typedef struct {
        logic            we;
        int              wr;
        logic [XLEN-1:0] wd;
        int              r1, r2;
        logic [XLEN-1:0] e1, e2;
    } vec_t;
    vec_t vecs [10];

    initial begin
        int nbusy, ndone, cnt;
        logic done_at_fall;

        vecs[0] = '{1'b1, 5, 64'hDEADBEEF_CAFEF00D, 5, 5, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D};
        vecs[1] = '{1'b0, 5, 64'h0, 5, 0, 64'hDEADBEEF_CAFEF00D, 64'h0};
        vecs[2] = '{1'b1, 0, 64'h1234, 0, 5, 64'h0, 64'hDEADBEEF_CAFEF00D};
        vecs[3] = '{1'b0, 0, 64'h0, 0, 0, 64'h0, 64'h0};
        vecs[4] = '{1'b1, 6, 64'hAA, 6, 5, 64'hAA, 64'hDEADBEEF_CAFEF00D};
        vecs[5] = '{1'b1, 6, 64'hBB, 6, 6, 64'hBB, 64'hBB};
        vecs[6] = '{1'b0, 0, 64'h0, 6, 31, 64'hBB, 64'h0};
        vecs[7] = '{1'b1, 31, 64'h77, 31, 1, 64'h77, 64'h0};
        vecs[8] = '{1'b0, 0, 64'h0, 31, 6, 64'h77, 64'hBB};
        vecs[9] = '{1'b1, 1, 64'h55, 2, 1, 64'h0, 64'h55};

        for (int i = 0; i < NREGS; i++) model[i] = '0;
        reset = 1'b1; reg_write = 1'b0; w_reg = '0; w_data = '0;
        r_reg1 = '0; r_reg2 = '0; clear_req = 1'b0;
`ifdef REGFILE_SCOREBOARD_EN
        issue_valid = 1'b0; issue_rd = '0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(clear_done), 64'h0);
        read_all("reset_read");

        // Directed vectors: same-cycle value checked before the commit edge.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            reg_write = vecs[i].we; w_reg = AW'(vecs[i].wr); w_data = vecs[i].wd;
            r_reg1 = AW'(vecs[i].r1); r_reg2 = AW'(vecs[i].r2);
            #1;
            check($sformatf("vec%0d_r1", i), r_data1, vecs[i].e1);
            check($sformatf("vec%0d_r2", i), r_data2, vecs[i].e2);
            if (vecs[i].we && vecs[i].wr != 0) model[vecs[i].wr] = vecs[i].wd;
        end
        @(negedge clk);
        reg_write = 1'b0;

        // Random traffic against the array model.
        for (int c = 0; c < 300; c++) begin
            int w, r1, r2;
            bit we;
            logic [XLEN-1:0] wd;
            @(negedge clk);
            we = ($urandom_range(0, 2) != 0);
            w  = $urandom_range(0, 4) == 0 ? 0 : $urandom_range(0, NREGS - 1);
            wd = {$urandom, $urandom};
            r1 = $urandom_range(0, 2) == 0 ? w : $urandom_range(0, NREGS - 1);
            r2 = $urandom_range(0, 3) == 0 ? w : $urandom_range(0, NREGS - 1);
            reg_write = we; w_reg = AW'(w); w_data = wd; r_reg1 = AW'(r1); r_reg2 = AW'(r2);
            #1;
            check("rand_r1", r_data1, exp_rd(r1, we, w, wd));
            check("rand_r2", r_data2, exp_rd(r2, we, w, wd));
            if (we && w != 0) model[w] = wd;
        end
        @(negedge clk);
        reg_write = 1'b0;

        // Bulk clear with a write attempted while busy.
        for (int i = 1; i < NREGS; i++) write_cycle(i, XLEN'(i));
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        nbusy = 0; ndone = 0; done_at_fall = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 0) begin
                reg_write = 1'b1; w_reg = AW'(7); w_data = 64'h99; r_reg1 = AW'(7);
                #1;
                check("busy_rise", 64'(busy), 64'h1);
                check("no_bypass_busy", r_data1, 64'h7);
            end else begin
                reg_write = 1'b0;
                #1;
            end
            if (busy) nbusy++;
            if (clear_done) begin
                ndone++;
                if (nbusy == NREGS) done_at_fall = 1'b1;
            end
            @(negedge clk);
        end
        check("clear_busy_cycles", 64'(nbusy), 64'(NREGS));
        check("clear_done_pulses", 64'(ndone), 64'h1);
        check("clear_done_timing", 64'(done_at_fall), 64'h1);
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        read_all("after_clear");

        // Reset in the middle of a clear.
        for (int i = 1; i < NREGS; i++) write_cycle(i, XLEN'(i + 100));
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        cnt = 0;
        while (cnt < 10 && busy) begin
            cnt++;
            @(negedge clk);
        end
        check("busy_before_reset", 64'(cnt), 64'd10);
        reset = 1'b1;
        #1;
        check("reset_mid_busy", 64'(busy), 64'h0);
        check("reset_mid_done", 64'(clear_done), 64'h0);
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        read_all("reset_mid_read");
        @(negedge clk);
        reset = 1'b0;
        nbusy = 0; ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (clear_done) ndone++;
        end
        check("post_reset_busy", 64'(nbusy), 64'h0);
        check("post_reset_done", 64'(ndone), 64'h0);
        write_cycle(3, 64'hABC);
        r_reg1 = AW'(3);
        #1;
        check("write_after_reset", r_data1, 64'hABC);

`ifdef REGFILE_SCOREBOARD_EN
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = AW'(9); r_reg1 = AW'(9); r_reg2 = AW'(0);
        @(negedge clk);
        issue_valid = 1'b0;
        #1;
        check("pend_issue", 64'(pend1), 64'h1);
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = AW'(9); reg_write = 1'b1; w_reg = AW'(9); w_data = 64'h5;
        @(negedge clk);
        issue_valid = 1'b0; reg_write = 1'b0;
        #1;
        check("pend_set_wins", 64'(pend1), 64'h1);
        @(negedge clk);
        reg_write = 1'b1; w_reg = AW'(9); w_data = 64'h6;
        #1;
        check("pend_bypass_mask", 64'(pend1), 64'h0);
        @(negedge clk);
        reg_write = 1'b0;
        #1;
        check("pend_cleared", 64'(pend1), 64'h0);
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = AW'(0);
        @(negedge clk);
        issue_valid = 1'b0;
        #1;
        check("pend_zero_reg", 64'(pend2), 64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
